// File: rtl/hs_pkg.sv
// Shared definitions for the hiscore RAM arbiter.
//   hs_state_t : arbiter FSM states (idle, pause requested, granted, settling)
//   SETTLE_W   : width of the release (settle) down-counter
package hs_pkg;

   localparam int unsigned SETTLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_GRANT  = 2'd2,
      ST_SETTLE = 2'd3
   } hs_state_t;

endpackage

// File: rtl/hs_ram_arbiter.sv
// Hiscore RAM arbiter: pauses the CPU, hands the shared RAM port to the
// hiscore engine, and returns it to the CPU after a short settle window.
// Ports:
//   clk_sys, reset                  clock, synchronous active-high reset
//   cpu_addr/cpu_din/cpu_we         CPU side of the RAM port
//   pause_ack / pause_req           handshake with the CPU pause system
//   hs_address/hs_data_in/hs_write  hiscore access (used only while granted)
//   hs_access_read/hs_access_write  hiscore intent to use the RAM
//   hs_data_out                     hiscore read data (captured while granted)
//   hs_grant                        hiscore currently owns the RAM
//   ram_addr/ram_din/ram_we         muxed RAM port
//   ram_dout                        RAM read data (1-cycle synchronous read)
module hs_ram_arbiter
   import hs_pkg::*;
#(
   parameter int unsigned AW     = 16,
   parameter int unsigned DW     = 8,
   parameter int unsigned SETTLE = 2
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   input  logic          cpu_we,
   input  logic          pause_ack,
   output logic          pause_req,
   input  logic [AW-1:0] hs_address,
   input  logic [DW-1:0] hs_data_in,
   input  logic          hs_write,
   input  logic          hs_access_read,
   input  logic          hs_access_write,
   output logic [DW-1:0] hs_data_out,
   output logic          hs_grant,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   hs_state_t             r_state;
   logic [SETTLE_W-1:0]   r_settle_cnt;
   logic                  r_pause_req;
   logic                  r_hs_grant;
   logic [DW-1:0]         r_hs_data;
   logic                  w_intent;

   assign w_intent = hs_access_read | hs_access_write;

   // Ownership FSM; pause_req and hs_grant are registered with the state.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
         r_pause_req  <= 1'b0;
         r_hs_grant   <= 1'b0;
         r_hs_data    <= '0;
      end else begin
         if (r_hs_grant) begin
            r_hs_data <= ram_dout;
         end
         case (r_state)
            ST_IDLE: begin
               // A CPU write in flight defers the pause request.
               if (w_intent && !cpu_we) begin
                  r_state     <= ST_REQ;
                  r_pause_req <= 1'b1;
               end
            end
            ST_REQ: begin
               if (!w_intent) begin
                  r_state     <= ST_IDLE;
                  r_pause_req <= 1'b0;
               end else if (pause_ack) begin
                  r_state    <= ST_GRANT;
                  r_hs_grant <= 1'b1;
               end
            end
            ST_GRANT: begin
               // Losing the acknowledge takes priority: fall back and re-request.
               if (!pause_ack) begin
                  r_state    <= ST_REQ;
                  r_hs_grant <= 1'b0;
               end else if (!w_intent) begin
                  r_state      <= ST_SETTLE;
                  r_hs_grant   <= 1'b0;
                  r_settle_cnt <= SETTLE_W'(SETTLE);
               end
            end
            ST_SETTLE: begin
               // Intent is ignored here; the CPU stays paused for SETTLE cycles.
               if (r_settle_cnt <= SETTLE_W'(1)) begin
                  r_state      <= ST_IDLE;
                  r_pause_req  <= 1'b0;
                  r_settle_cnt <= '0;
               end else begin
                  r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_pause_req <= 1'b0;
               r_hs_grant  <= 1'b0;
            end
         endcase
      end
   end

   // RAM port mux; a write is only passed while its owner is legitimately active.
   assign ram_addr = r_hs_grant ? hs_address : cpu_addr;
   assign ram_din  = r_hs_grant ? hs_data_in : cpu_din;
   assign ram_we   = r_hs_grant ? (hs_write & pause_ack) : (cpu_we & ~pause_ack);

   assign pause_req   = r_pause_req;
   assign hs_grant    = r_hs_grant;
   assign hs_data_out = r_hs_data;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: directed vector table, hand-written corner
// sequences, and random stimulus checked against a behavioural model.
module tb_hs_ram_arbiter;

   localparam int unsigned TB_SETTLE = 2;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic        cpu_we = 1'b0;
   logic        pause_ack = 1'b0;
   logic        pause_req;
   logic [15:0] hs_address = '0;
   logic [7:0]  hs_data_in = '0;
   logic        hs_write = 1'b0;
   logic        hs_access_read = 1'b0;
   logic        hs_access_write = 1'b0;
   logic [7:0]  hs_data_out;
   logic        hs_grant;
   logic [15:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout = '0;

   hs_ram_arbiter #(.AW(16), .DW(8), .SETTLE(TB_SETTLE)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
      .pause_ack(pause_ack), .pause_req(pause_req),
      .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
      .hs_access_read(hs_access_read), .hs_access_write(hs_access_write),
      .hs_data_out(hs_data_out), .hs_grant(hs_grant),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_dout(ram_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Synchronous single-port RAM behind the arbiter.
   logic [7:0] ram_mem [0:65535];
   always @(posedge clk_sys) begin
      if (ram_we === 1'b1) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   typedef struct {
      logic        rst;
      logic        cpu_we;
      logic        rd;
      logic        wr;
      logic        ack;
      logic        hs_wr;
      logic [15:0] addr;
      logic [7:0]  din;
      logic [15:0] c_addr;
      logic [7:0]  c_din;
   } in_t;

   typedef struct {
      in_t        i;
      logic       e_preq;
      logic       e_grant;
      logic       c_dout;
      logic [7:0] e_dout;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: who owns the RAM and how long the release lasts.
   // phase 0 = CPU owns, 1 = asking CPU to pause, 2 = hiscore owns, 3 = releasing
   int         m_phase = 0;
   int         m_left  = 0;
   logic [7:0] m_dout  = '0;
   logic [7:0] m_rdata = '0;
   logic [7:0] shadow [0:65535];
   bit         m_on = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_bus(output logic [15:0] a, output logic [7:0] d, output logic we);
      if (m_phase == 2) begin
         a  = hs_address;
         d  = hs_data_in;
         we = hs_write & pause_ack;
      end else begin
         a  = cpu_addr;
         d  = cpu_din;
         we = cpu_we & ~pause_ack;
      end
   endtask

   task automatic model_step();
      logic        intent;
      logic [15:0] a;
      logic [7:0]  d;
      logic        we;
      logic [7:0]  rd_now;
      intent = hs_access_read | hs_access_write;
      model_bus(a, d, we);
      rd_now  = m_rdata;
      m_rdata = shadow[a];
      if (we) shadow[a] = d;
      if (reset) begin
         m_phase = 0;
         m_left  = 0;
         m_dout  = '0;
      end else begin
         if (m_phase == 2) m_dout = rd_now;
         case (m_phase)
            0: if (intent && !cpu_we) m_phase = 1;
            1: if (!intent) m_phase = 0; else if (pause_ack) m_phase = 2;
            2: if (!pause_ack) m_phase = 1;
               else if (!intent) begin m_phase = 3; m_left = TB_SETTLE; end
            default: begin
               m_left = m_left - 1;
               if (m_left == 0) m_phase = 0;
            end
         endcase
      end
   endtask

   // Apply inputs after the falling edge and compare everything to the model.
   task automatic drive(input in_t v);
      logic [15:0] a;
      logic [7:0]  d;
      logic        we;
      reset           = v.rst;
      cpu_we          = v.cpu_we;
      hs_access_read  = v.rd;
      hs_access_write = v.wr;
      pause_ack       = v.ack;
      hs_write        = v.hs_wr;
      hs_address      = v.addr;
      hs_data_in      = v.din;
      cpu_addr        = v.c_addr;
      cpu_din         = v.c_din;
      #1;
      if (m_on) begin
         model_bus(a, d, we);
         check("model", {29'd0, pause_req, hs_grant, ram_we, hs_data_out, ram_addr, ram_din},
               {29'd0, 1'(m_phase != 0), 1'(m_phase == 2), we, m_dout, a, d});
      end
   endtask

   task automatic tick();
      model_step();
      @(negedge clk_sys);
   endtask

   task automatic run(input in_t v);
      drive(v);
      tick();
   endtask

   function automatic vec_t mk(input logic cwe, input logic rd, input logic ack,
                               input logic p, input logic g, input logic cd, input logic [7:0] d);
      vec_t r;
      r.i        = '{default: '0};
      r.i.cpu_we = cwe;
      r.i.rd     = rd;
      r.i.ack    = ack;
      r.i.addr   = 16'h6100;
      r.e_preq   = p;
      r.e_grant  = g;
      r.c_dout   = cd;
      r.e_dout   = d;
      return r;
   endfunction

   initial begin
      vec_t tbl [24];
      in_t  v;

      for (int k = 0; k < 65536; k++) begin
         ram_mem[k] = 8'h00;
         shadow[k]  = 8'h00;
      end
      ram_mem[16'h6100] = 8'hA5;
      shadow[16'h6100]  = 8'hA5;

      // Deferral, read grant, settle with an ignored intent pulse, abandoned request.
      for (int k = 0; k < 5; k++) tbl[k] = mk(1, 1, 0, 0, 0, 0, 8'h00);
      tbl[5]  = mk(0, 1, 0, 0, 0, 0, 8'h00);
      tbl[6]  = mk(0, 1, 0, 1, 0, 0, 8'h00);
      tbl[7]  = mk(0, 1, 0, 1, 0, 0, 8'h00);
      tbl[8]  = mk(0, 1, 0, 1, 0, 0, 8'h00);
      tbl[9]  = mk(0, 1, 1, 1, 0, 0, 8'h00);
      tbl[10] = mk(0, 1, 1, 1, 1, 1, 8'h00);
      tbl[11] = mk(0, 1, 1, 1, 1, 1, 8'h00);
      tbl[12] = mk(0, 0, 1, 1, 1, 1, 8'hA5);
      tbl[13] = mk(0, 1, 1, 1, 0, 1, 8'hA5);
      tbl[14] = mk(0, 1, 1, 1, 0, 0, 8'h00);
      tbl[15] = mk(0, 1, 1, 0, 0, 0, 8'h00);
      tbl[16] = mk(0, 1, 1, 1, 0, 0, 8'h00);
      tbl[17] = mk(0, 0, 1, 1, 1, 0, 8'h00);
      tbl[18] = mk(0, 0, 1, 1, 0, 0, 8'h00);
      tbl[19] = mk(0, 0, 1, 1, 0, 0, 8'h00);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 8'h00);
      tbl[21] = mk(0, 1, 0, 0, 0, 0, 8'h00);
      tbl[22] = mk(0, 0, 0, 1, 0, 0, 8'h00);
      tbl[23] = mk(0, 0, 0, 0, 0, 0, 8'h00);

      @(negedge clk_sys);

      // Reset state
      v     = '{default: '0};
      v.rst = 1'b1;
      run(v);
      m_on = 1;
      run(v);
      v.rst = 1'b0;
      drive(v);
      check("reset_state", {pause_req, hs_grant, hs_data_out}, 10'd0);
      tick();

      // Vector table
      for (int k = 0; k < 24; k++) begin
         drive(tbl[k].i);
         check($sformatf("tbl%0d_preq_grant", k), {pause_req, hs_grant}, {tbl[k].e_preq, tbl[k].e_grant});
         if (tbl[k].c_dout) check($sformatf("tbl%0d_dout", k), hs_data_out, tbl[k].e_dout);
         tick();
      end

      // Hiscore write while granted; CPU writes in the same window are blocked.
      v     = '{default: '0};
      v.wr  = 1'b1;
      v.ack = 1'b1;
      run(v);
      run(v);
      v.hs_wr  = 1'b1;
      v.addr   = 16'h6101;
      v.din    = 8'h3C;
      v.cpu_we = 1'b1;
      v.c_addr = 16'h6101;
      v.c_din  = 8'hFF;
      drive(v);
      check("wr_grant", hs_grant, 1'b1);
      check("wr_bus", {ram_we, ram_din}, {1'b1, 8'h3C});
      tick();
      v.hs_wr = 1'b0;
      drive(v);
      check("wr_cpu_blocked", ram_we, 1'b0);
      tick();
      v.wr     = 1'b0;
      v.cpu_we = 1'b0;
      for (int k = 0; k < 4; k++) run(v);
      check("wr_mem", ram_mem[16'h6101], 8'h3C);
      v.ack = 1'b0;
      run(v);

      // Reset mid-grant releases everything without a settle phase.
      v      = '{default: '0};
      v.rd   = 1'b1;
      v.ack  = 1'b1;
      v.addr = 16'h6100;
      for (int k = 0; k < 4; k++) run(v);
      drive(v);
      check("abort_pre_dout", {hs_grant, hs_data_out}, {1'b1, 8'hA5});
      tick();
      v.rst = 1'b1;
      run(v);
      v.rst = 1'b0;
      v.rd  = 1'b0;
      drive(v);
      check("abort_post", {pause_req, hs_grant, hs_data_out}, 10'd0);
      tick();
      v.ack = 1'b0;
      run(v);

      // External unpause during a granted write.
      v      = '{default: '0};
      v.wr   = 1'b1;
      v.ack  = 1'b1;
      v.addr = 16'h6102;
      v.din  = 8'h77;
      run(v);
      run(v);
      v.hs_wr = 1'b1;
      v.ack   = 1'b0;
      drive(v);
      check("unpause_we", {hs_grant, ram_we}, {1'b1, 1'b0});
      tick();
      drive(v);
      check("unpause_req", {pause_req, hs_grant}, {1'b1, 1'b0});
      tick();
      v.ack   = 1'b1;
      v.hs_wr = 1'b0;
      run(v);
      drive(v);
      check("unpause_regrant", hs_grant, 1'b1);
      tick();
      v.wr = 1'b0;
      for (int k = 0; k < 4; k++) run(v);
      check("unpause_mem", ram_mem[16'h6102], 8'h00);

      // Random traffic against the model.
      v = '{default: '0};
      for (int n = 0; n < 3000; n++) begin
         v.rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) v.rd  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) v.wr  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) v.ack = 1'($urandom_range(0, 1));
         v.cpu_we = ($urandom_range(0, 3) == 0);
         v.hs_wr  = 1'($urandom_range(0, 1));
         v.addr   = 16'h6100 + 16'($urandom_range(0, 7));
         v.din    = 8'($urandom);
         v.c_addr = 16'h6100 + 16'($urandom_range(0, 7));
         v.c_din  = 8'($urandom);
         run(v);
         if (hs_grant === 1'b1 && ram_we === 1'b1 && cpu_we === 1'b1 && hs_write === 1'b0)
            check("excl", 1'b1, 1'b0);
      end
      for (int k = 0; k < 8; k++)
         check($sformatf("mem_%0d", k), ram_mem[16'h6100 + 16'(k)], shadow[16'h6100 + 16'(k)]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 Parameter AW, default 16, RAM address width in bits.
REQ-002 Parameter DW, default 8, RAM data width in bits.
REQ-003 Parameter SETTLE, default 2, number of release cycles before returning the RAM to the CPU (legal range 1..15).
REQ-004 Ports SHALL be:
- clk_sys  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- cpu_addr  in  AW  CPU RAM address.
- cpu_din  in  DW  CPU write data.
- cpu_we  in  1  CPU write strobe.
- pause_ack  in  1  CPU confirmed halted (from the pause system).
- pause_req  out  1  request to halt the CPU.
- hs_address  in  AW  hiscore address.
- hs_data_in  in  DW  hiscore write data.
- hs_write  in  1  hiscore write strobe.
- hs_access_read  in  1  hiscore read intent.
- hs_access_write  in  1  hiscore write intent.
- hs_data_out  out  DW  hiscore read data.
- hs_grant  out  1  RAM currently owned by hiscore.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DW  RAM read data (1-cycle synchronous read).

Function
REQ-005 The FSM states SHALL be IDLE, REQ, GRANT and SETTLE.
REQ-006 IDLE -> REQ when (hs_access_read|hs_access_write)=1 and cpu_we=0; if cpu_we=1 the transition is deferred, one cycle at a time, until cpu_we=0.
REQ-007 In REQ, pause_req SHALL be 1; REQ -> GRANT on the first cycle pause_ack=1.
REQ-008 If intent drops while in REQ, REQ -> IDLE next cycle with pause_req=0 and no RAM access.
REQ-009 In GRANT: hs_grant=1, pause_req=1, ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write.
REQ-010 GRANT -> SETTLE when both intents are 0.
REQ-011 In SETTLE, pause_req SHALL stay 1 for exactly SETTLE cycles, counted by a down-counter; the RAM mux returns to the CPU on the first SETTLE cycle; then -> IDLE.
REQ-012 New intent during SETTLE SHALL be ignored until IDLE is reached (no direct re-grant).
REQ-013 In IDLE, REQ and SETTLE: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we & ~pause_ack.
REQ-014 hs_data_out SHALL register ram_dout every cycle hs_grant=1 and hold otherwise; valid read data appears 2 cycles after hs_address is presented.
REQ-015 If pause_ack falls during GRANT (external unpause), the FSM SHALL go to REQ, drop hs_grant, and suppress ram_we that same cycle.
REQ-016 hs_write while hs_grant=0 SHALL never reach ram_we.
REQ-017 hs_grant and CPU write pass-through SHALL be mutually exclusive in every cycle.

Reset
REQ-018 On reset=1 at a clk_sys edge: state=IDLE, pause_req=0, hs_grant=0, hs_data_out=0, settle counter=0; ram_* follow the CPU mux.
REQ-019 Reset asserted mid-GRANT SHALL release pause_req on the following cycle without a SETTLE phase.

Structure
REQ-020 The state enum and the SETTLE width constant (4 bits) SHALL live in the shared core package hs_pkg.
REQ-021 The block SHALL be a single module with no sub-modules; the settle counter is inline.

Verification
REQ-022 Read: hs_access_read=1, hs_address=16'h6100, RAM[6100]=8'hA5, pause_ack rising 3 cycles after pause_req -> hs_grant on the 4th cycle, hs_data_out=8'hA5 two cycles later.
REQ-023 Write: in GRANT, hs_write=1, hs_data_in=8'h3C, addr 16'h6101 -> RAM[6101]=8'h3C; cpu_we=1 pulses in the same window are blocked.
REQ-024 Deferral: cpu_we=1 for 5 cycles while intent rises -> pause_req stays 0 until the cycle after cpu_we falls.
REQ-025 Settle: SETTLE=2; intent drops -> pause_req stays 1 exactly 2 more cycles; an intent pulse in that window causes no grant until after IDLE.
REQ-026 Abort: reset pulsed mid-GRANT -> next cycle pause_req=0, hs_grant=0, hs_data_out=0.
REQ-027 Unpause: pause_ack dropped mid-GRANT with hs_write=1 -> no RAM write, state REQ, re-grant when pause_ack returns.
